// File: rtl/zero_remover.sv
`default_nettype none
// ============================================================================
//  Module   : zero_remover
//  Purpose  : Pyramid-down decimator. Consumes a full-resolution FP pixel
//             stream (data/col/row/valid) and forwards only the on-grid
//             samples, i.e. those whose row and column are both multiples of
//             2^(SCALE+1). Output coordinates are remapped to the decimated
//             image. A raster-order checker tracks the expected input
//             position, raises a sticky error on any deviation and resyncs.
//             The last on-grid pixel of every frame carries a one-cycle
//             frame_done_o pulse.
//
//  Ports    : clk_i         single clock, all logic on posedge
//             rst_n_i       synchronous active-low reset
//             data_i        input pixel (FP_WIDTH_REG bits)
//             col_i/row_i   input coordinates (16 bits each)
//             valid_i       input qualifier, no backpressure
//             data_o        kept pixel
//             col_o/row_o   decimated coordinates (coord >> (SCALE+1))
//             valid_o       output qualifier
//             frame_done_o  pulse with the last decimated pixel of a frame
//             seq_err_o     sticky raster-order error flag
//             kept_cnt_o    (only with ZERO_REMOVER_STATS_EN) number of
//                           valid_o pulses since the last frame_done_o
//
//  Options  : `define ZERO_REMOVER_STATS_EN to add the kept_cnt_o counter.
//
//  Latency  : 2 cycles (S1 input register, S2 output register).
//
//  Revision : 1.0 - initial release
// ============================================================================
module zero_remover #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int SCALE      = 0,
  parameter int DISABLE    = 0,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] data_o,
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o,
  output logic                    frame_done_o,
  output logic                    seq_err_o
`ifdef ZERO_REMOVER_STATS_EN
  ,
  output logic [31:0]             kept_cnt_o
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_shift    = SCALE + 1;
  localparam int          c_step     = 1 << c_shift;
  localparam logic        c_bypass   = (DISABLE != 0);
  localparam logic [15:0] c_last_col = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] c_last_row = 16'(IMG_HEIGHT - 1);

  // Coordinates (input space) of the pixel that closes a frame. In bypass
  // mode every pixel is forwarded, so the very last raster position closes it.
  localparam logic [15:0] c_done_col = c_bypass ? 16'(IMG_WIDTH - 1)
                                                : 16'(IMG_WIDTH - c_step);
  localparam logic [15:0] c_done_row = c_bypass ? 16'(IMG_HEIGHT - 1)
                                                : 16'(IMG_HEIGHT - c_step);

  // --------------------------------------------------------------------------
  // S1: input register plus on-grid decision
  // --------------------------------------------------------------------------
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_keep_q,  s1_keep_d;
  logic [FP_WIDTH_REG-1:0] s1_data_q,  s1_data_d;
  logic [15:0]             s1_col_q,   s1_col_d;
  logic [15:0]             s1_row_q,   s1_row_d;

  always_comb begin
    s1_valid_d = valid_i;
    s1_data_d  = data_i;
    s1_col_d   = col_i;
    s1_row_d   = row_i;
    // On-grid only when the low SCALE+1 bits of both coordinates are zero.
    // Out-of-range coordinates still follow this rule.
    s1_keep_d  = c_bypass |
                 ((row_i[SCALE:0] == '0) && (col_i[SCALE:0] == '0));
  end

  // --------------------------------------------------------------------------
  // Raster-order checker (operates on S1 values)
  // --------------------------------------------------------------------------
  logic [15:0] exp_r_q, exp_r_d;
  logic [15:0] exp_c_q, exp_c_d;
  logic        seq_err_q, seq_err_d;
  logic        w_match;
  logic [15:0] w_base_row;
  logic [15:0] w_base_col;

  always_comb begin
    exp_r_d    = exp_r_q;
    exp_c_d    = exp_c_q;
    seq_err_d  = seq_err_q;
    w_match    = (s1_row_q == exp_r_q) && (s1_col_q == exp_c_q);
    w_base_row = exp_r_q;
    w_base_col = exp_c_q;

    if (s1_valid_q) begin
      // On a mismatch the next expected position is derived from what was
      // actually received, so a single glitch costs exactly one error event.
      // The expected counters never leave the image, so out-of-range input
      // coordinates always land here.
      if (!w_match) begin
        seq_err_d  = 1'b1;
        w_base_row = s1_row_q;
        w_base_col = s1_col_q;
      end

      if (w_base_col >= c_last_col) begin
        exp_c_d = 16'd0;
        exp_r_d = (w_base_row >= c_last_row) ? 16'd0 : w_base_row + 16'd1;
      end else begin
        exp_c_d = w_base_col + 16'd1;
        exp_r_d = w_base_row;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: output register
  // --------------------------------------------------------------------------
  logic                    valid_o_q,      valid_o_d;
  logic                    frame_done_o_q, frame_done_o_d;
  logic [FP_WIDTH_REG-1:0] data_o_q,       data_o_d;
  logic [15:0]             col_o_q,        col_o_d;
  logic [15:0]             row_o_q,        row_o_d;
  logic                    w_at_done;

  always_comb begin
    w_at_done      = (s1_row_q == c_done_row) && (s1_col_q == c_done_col);
    valid_o_d      = s1_valid_q & s1_keep_q;
    frame_done_o_d = s1_valid_q & s1_keep_q & w_at_done;
    // Data and coordinates hold their last forwarded value on idle cycles.
    data_o_d       = data_o_q;
    col_o_d        = col_o_q;
    row_o_d        = row_o_q;

    if (valid_o_d) begin
      data_o_d = s1_data_q;
      if (c_bypass) begin
        col_o_d = s1_col_q;
        row_o_d = s1_row_q;
      end else begin
        col_o_d = s1_col_q >> c_shift;
        row_o_d = s1_row_q >> c_shift;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid_q     <= 1'b0;
      s1_keep_q      <= 1'b0;
      s1_data_q      <= '0;
      s1_col_q       <= 16'd0;
      s1_row_q       <= 16'd0;
      exp_r_q        <= 16'd0;
      exp_c_q        <= 16'd0;
      seq_err_q      <= 1'b0;
      valid_o_q      <= 1'b0;
      frame_done_o_q <= 1'b0;
      data_o_q       <= '0;
      col_o_q        <= 16'd0;
      row_o_q        <= 16'd0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_keep_q      <= s1_keep_d;
      s1_data_q      <= s1_data_d;
      s1_col_q       <= s1_col_d;
      s1_row_q       <= s1_row_d;
      exp_r_q        <= exp_r_d;
      exp_c_q        <= exp_c_d;
      seq_err_q      <= seq_err_d;
      valid_o_q      <= valid_o_d;
      frame_done_o_q <= frame_done_o_d;
      data_o_q       <= data_o_d;
      col_o_q        <= col_o_d;
      row_o_q        <= row_o_d;
    end
  end

  assign data_o       = data_o_q;
  assign col_o        = col_o_q;
  assign row_o        = row_o_q;
  assign valid_o      = valid_o_q;
  assign frame_done_o = frame_done_o_q;
  assign seq_err_o    = seq_err_q;

`ifdef ZERO_REMOVER_STATS_EN
  // --------------------------------------------------------------------------
  // Kept-pixel counter. Tracks valid_o on the same edge that produces it;
  // the frame-closing pixel clears the counter instead of incrementing it.
  // --------------------------------------------------------------------------
  logic [31:0] kept_cnt_q, kept_cnt_d;

  always_comb begin
    kept_cnt_d = kept_cnt_q;
    if (frame_done_o_d) begin
      kept_cnt_d = 32'd0;
    end else if (valid_o_d) begin
      kept_cnt_d = kept_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      kept_cnt_q <= 32'd0;
    end else begin
      kept_cnt_q <= kept_cnt_d;
    end
  end

  assign kept_cnt_o = kept_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zero_remover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zero_remover
//  Purpose  : Directed self-checking bench for zero_remover. Four instances
//             with different geometries share one input stream; each test
//             resets, selects one instance and checks its captured outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zero_remover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic [15:0] col_i;
  logic [15:0] row_i;
  logic        valid_i;

  logic [31:0] d_o  [4];
  logic [15:0] c_o  [4];
  logic [15:0] r_o  [4];
  logic        v_o  [4];
  logic        fd_o [4];
  logic        se_o [4];
`ifdef ZERO_REMOVER_STATS_EN
  logic [31:0] k_o  [4];
`endif

  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // 0: SCALE=0 8x4   1: SCALE=2 16x16   2: DISABLE 4x4   3: SCALE=1 8x8
  zero_remover #(.SCALE(0), .DISABLE(0), .IMG_WIDTH(8), .IMG_HEIGHT(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .data_o(d_o[0]), .col_o(c_o[0]), .row_o(r_o[0]),
    .valid_o(v_o[0]), .frame_done_o(fd_o[0]), .seq_err_o(se_o[0])
`ifdef ZERO_REMOVER_STATS_EN
    , .kept_cnt_o(k_o[0])
`endif
  );

  zero_remover #(.SCALE(2), .DISABLE(0), .IMG_WIDTH(16), .IMG_HEIGHT(16)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .data_o(d_o[1]), .col_o(c_o[1]), .row_o(r_o[1]),
    .valid_o(v_o[1]), .frame_done_o(fd_o[1]), .seq_err_o(se_o[1])
`ifdef ZERO_REMOVER_STATS_EN
    , .kept_cnt_o(k_o[1])
`endif
  );

  zero_remover #(.SCALE(0), .DISABLE(1), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .data_o(d_o[2]), .col_o(c_o[2]), .row_o(r_o[2]),
    .valid_o(v_o[2]), .frame_done_o(fd_o[2]), .seq_err_o(se_o[2])
`ifdef ZERO_REMOVER_STATS_EN
    , .kept_cnt_o(k_o[2])
`endif
  );

  zero_remover #(.SCALE(1), .DISABLE(0), .IMG_WIDTH(8), .IMG_HEIGHT(8)) u_dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .data_o(d_o[3]), .col_o(c_o[3]), .row_o(r_o[3]),
    .valid_o(v_o[3]), .frame_done_o(fd_o[3]), .seq_err_o(se_o[3])
`ifdef ZERO_REMOVER_STATS_EN
    , .kept_cnt_o(k_o[3])
`endif
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int r, input int c);
    return 32'h3F80_0000 | (32'(r) << 8) | 32'(c);
  endfunction

  // --------------------------------------------------------------------------
  // Output capture on the falling edge
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] c;
    logic [31:0] d;
    logic        fd;
    logic [31:0] cyc;
  } out_t;

  out_t        q[$];
  int          sel       = 0;
  logic        cap_en    = 1'b0;
  logic        have_prev = 1'b0;
  logic [63:0] prev_out;
  int          hold_viol = 0;
  int          stray_fd  = 0;
`ifdef ZERO_REMOVER_STATS_EN
  logic [31:0] prev_kept = 32'd0;
  logic [31:0] kb[$];
  logic [31:0] ka[$];
`endif

  always @(negedge clk) begin
    out_t e;
    if (cap_en) begin
      if (v_o[sel]) begin
        e.r   = r_o[sel];
        e.c   = c_o[sel];
        e.d   = d_o[sel];
        e.fd  = fd_o[sel];
        e.cyc = cyc;
        q.push_back(e);
      end else begin
        if (have_prev && ({r_o[sel], c_o[sel], d_o[sel]} !== prev_out)) hold_viol++;
        if (fd_o[sel]) stray_fd++;
      end
`ifdef ZERO_REMOVER_STATS_EN
      if (fd_o[sel]) begin
        kb.push_back(prev_kept);
        ka.push_back(k_o[sel]);
      end
      prev_kept = k_o[sel];
`endif
      prev_out  = {r_o[sel], c_o[sel], d_o[sel]};
      have_prev = 1'b1;
    end
  end

  task automatic start_cap(input int s);
    sel       = s;
    q.delete();
    hold_viol = 0;
    stray_fd  = 0;
    have_prev = 1'b0;
`ifdef ZERO_REMOVER_STATS_EN
    kb.delete();
    ka.delete();
    prev_kept = 32'd0;
`endif
    cap_en    = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int r, input int c);
    valid_i = v;
    row_i   = 16'(r);
    col_i   = 16'(c);
    data_i  = pix(r, c);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid_i = 1'b0;
      row_i   = 16'($urandom);
      col_i   = 16'($urandom);
      data_i  = $urandom;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    tick();
    rst_n   = 1'b1;
  endtask

  task automatic raster(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        drive(1'b1, r, c);
  endtask

  // Output i of a decimated frame sits at (i / w_out, i % w_out) and carries
  // the input pixel at step times those coordinates; only the last one pulses.
  task automatic check_frame(input string tag, input int n_exp, input int w_out, input int step);
    check({tag, "_count"}, 64'(q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < q.size(); i++) begin
      check($sformatf("%s_coord%0d", tag, i), {32'd0, q[i].r, q[i].c},
            {32'd0, 16'(i / w_out), 16'(i % w_out)});
      check($sformatf("%s_data%0d", tag, i), {32'd0, q[i].d},
            {32'd0, pix(step * (i / w_out), step * (i % w_out))});
      check($sformatf("%s_fd%0d", tag, i), {63'd0, q[i].fd}, {63'd0, (i == n_exp - 1)});
    end
    check({tag, "_stray_fd"}, 64'(stray_fd), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] t0;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 32'd0;
    col_i   = 16'd0;
    row_i   = 16'd0;
    tick();

    // T1: SCALE=0, 8x4, continuous raster
    do_reset();
    check("reset_valid", {63'd0, v_o[0]}, 64'd0);
    check("reset_fd", {63'd0, fd_o[0]}, 64'd0);
    check("reset_err", {63'd0, se_o[0]}, 64'd0);
    check("reset_outs", {r_o[0], c_o[0], d_o[0]}, 64'd0);
    start_cap(0);
    t0 = cyc;
    raster(8, 4);
    idle(3);
    cap_en = 1'b0;
    check_frame("t1", 8, 4, 2);
    check("t1_latency", (q.size() > 0) ? 64'(q[0].cyc - t0) : 64'hFFFF, 64'd2);
    check("t1_err", {63'd0, se_o[0]}, 64'd0);
    check("t1_hold", 64'(hold_viol), 64'd0);

    // T2: SCALE=2, 16x16, random gaps with garbage coordinates
    do_reset();
    start_cap(1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, r, c);
        idle(int'($urandom_range(0, 2)));
      end
    idle(3);
    cap_en = 1'b0;
    check_frame("t2", 4, 2, 8);
    check("t2_hold", 64'(hold_viol), 64'd0);
    check("t2_err", {63'd0, se_o[1]}, 64'd0);

    // T3: DISABLE=1, 4x4, everything passes unshifted
    do_reset();
    start_cap(2);
    raster(4, 4);
    idle(3);
    cap_en = 1'b0;
    check_frame("t3", 16, 4, 1);
    check("t3_err", {63'd0, se_o[2]}, 64'd0);

    // T4: SCALE=1, 8x8, input (0,5) skipped
    do_reset();
    start_cap(3);
    for (int c = 0; c < 5; c++) drive(1'b1, 0, c);
    idle(2);
    check("t4_err_before", {63'd0, se_o[3]}, 64'd0);
    drive(1'b1, 0, 6);
    check("t4_err_not_early", {63'd0, se_o[3]}, 64'd0);
    idle(1);
    check("t4_err_rise", {63'd0, se_o[3]}, 64'd1);
    drive(1'b1, 0, 7);
    for (int r = 1; r < 8; r++)
      for (int c = 0; c < 8; c++)
        drive(1'b1, r, c);
    idle(3);
    cap_en = 1'b0;
    check("t4_err_sticky", {63'd0, se_o[3]}, 64'd1);
    check_frame("t4", 4, 2, 4);

    // T5: out-of-range coordinate, reset mid-frame, in-flight discard
    do_reset();
    start_cap(0);
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 1);
    drive(1'b1, 0, 8);
    idle(2);
    check("t5_oor_err", {63'd0, se_o[0]}, 64'd1);
    check("t5_oor_count", 64'(q.size()), 64'd2);
    check("t5_oor_coord", (q.size() > 1) ? {32'd0, q[1].r, q[1].c} : 64'hFFFF, 64'h0000_0000_0000_0004);
    check("t5_oor_data", (q.size() > 1) ? {32'd0, q[1].d} : 64'hFFFF, {32'd0, pix(0, 8)});
    for (int r = 1; r < 3; r++)
      for (int c = 0; c < 8; c++)
        drive(1'b1, r, c);
    drive(1'b1, 3, 0);
    drive(1'b1, 3, 1);
    check("t5_err_pre_reset", {63'd0, se_o[0]}, 64'd1);
    rst_n = 1'b0;
    drive(1'b1, 3, 2);
    rst_n = 1'b1;
    start_cap(0);
    check("t5_valid_after_reset", {63'd0, v_o[0]}, 64'd0);
    check("t5_err_cleared", {63'd0, se_o[0]}, 64'd0);
    drive(1'b1, 0, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("t5_discard", 64'(q.size()), 64'd0);
    start_cap(0);
    raster(8, 4);
    idle(3);
    cap_en = 1'b0;
    check_frame("t5", 8, 4, 2);
    check("t5_err", {63'd0, se_o[0]}, 64'd0);

`ifdef ZERO_REMOVER_STATS_EN
    // T6: kept-pixel counter over two back-to-back frames
    do_reset();
    check("t6_cnt_reset", {32'd0, k_o[0]}, 64'd0);
    start_cap(0);
    raster(8, 4);
    raster(8, 4);
    idle(3);
    cap_en = 1'b0;
    check("t6_count", 64'(q.size()), 64'd16);
    check("t6_fd_events", 64'(kb.size()), 64'd2);
    for (int i = 0; i < 2 && i < kb.size(); i++) begin
      check($sformatf("t6_cnt_before%0d", i), {32'd0, kb[i]}, 64'd7);
      check($sformatf("t6_cnt_at%0d", i), {32'd0, ka[i]}, 64'd0);
    end
    check("t6_err", {63'd0, se_o[0]}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
